// File: rtl/spi_reg_master_if.sv
// Request/response handshake and SPI pin bundle for spi_reg_master.
// The slave modport is taken by the block; the master modport by the requester/board side.
`timescale 1ns/1ps
interface spi_reg_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       SCK;
  logic       CS;
  logic       MOSI;
  logic       MISO;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, MISO,
    input  req_ready, rsp_valid, rsp_rdata, SCK, CS, MOSI
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, MISO,
    output req_ready, rsp_valid, rsp_rdata, SCK, CS, MOSI
  );
endinterface

// File: rtl/spi_reg_master.sv
// Mode-0 SPI master issuing one 16-bit register write/read frame per request.
// All pin and handshake outputs are registered from next-state decode.
`timescale 1ns/1ps
module spi_reg_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_reg_master_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  half_q, half_d;
  logic [3:0]  bit_q, bit_d;
  logic        gap2_q, gap2_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        miso_s1_q, miso_s2_q;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        half_done_s;

  assign half_done_s = (half_q == 8'd0);

  // Next-state and output decode; GAP spans two half-period counts.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    gap2_d  = gap2_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_d = S_LOW;
          half_d  = HALF_RELOAD;
          bit_d   = 4'd15;
          tx_d    = {bus.req_we, bus.req_addr, (bus.req_we ? bus.req_wdata : 8'h00)};
          rx_d    = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOW: begin
        if (half_done_s) begin
          state_d = S_HIGH;
          half_d  = HALF_RELOAD;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (half_done_s) begin
          rx_d   = {rx_q[6:0], miso_s2_q};
          half_d = HALF_RELOAD;
          if (bit_q == 4'd0) begin
            state_d = S_TRAIL;
          end else begin
            state_d = S_LOW;
            bit_d   = bit_q - 4'd1;
            tx_d    = {tx_q[14:0], 1'b0};
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      S_TRAIL: begin
        if (half_done_s) begin
          state_d = S_GAP;
          half_d  = HALF_RELOAD;
          gap2_d  = 1'b0;
          rdata_d = rx_q;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      S_GAP: begin
        if (half_done_s) begin
          half_d = HALF_RELOAD;
          if (gap2_q) begin
            state_d = S_IDLE;
            gap2_d  = 1'b0;
          end else begin
            gap2_d = 1'b1;
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cs_d        = !(state_d inside {S_LOW, S_HIGH, S_TRAIL});
    sck_d       = (state_d == S_HIGH);
    // MOSI follows the TX MSB, which only moves when a new LOW phase starts.
    mosi_d      = (state_d inside {S_LOW, S_HIGH}) ? tx_d[15] : 1'b0;
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_q == S_TRAIL) && (state_d == S_GAP);
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      half_q      <= 8'd0;
      bit_q       <= 4'd0;
      gap2_q      <= 1'b0;
      tx_q        <= 16'h0000;
      rx_q        <= 8'h00;
      rdata_q     <= 8'h00;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      gap2_q      <= gap2_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Two-flop synchronizer for the slave's MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= bus.MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign bus.CS        = cs_q;
  assign bus.SCK       = sck_q;
  assign bus.MOSI      = mosi_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Scoreboard bench: register-file slave model on the SPI pins, reference register
// map for expected read data, plus per-divider timing sweeps on separate instances.
`timescale 1ns/1ps
module tb_spi_reg_master;
  localparam int D = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic rst_sw = 1'b0;
  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;
  int cyc = 0;
  int accepted = 0;
  int responses = 0;
  int sweep_done = 0;
  int cs_rise_cyc = 0;
  int cs_fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];
  logic [7:0]  ref_regs   [128];
  logic [7:0]  slave_regs [128];

  spi_reg_master_if bus();
  spi_reg_master #(.CLK_DIV(D)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input longint act, input longint exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks_total++;
    $display("FAIL %s: got timeout/unexpected event, required normal completion", name);
  endtask

  task automatic issue(input logic we, input logic [6:0] addr, input logic [7:0] wdata,
                       input bit tracked, input bit hold_valid);
    int n = 0;
    @(negedge clk);
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
    end else begin
      if (tracked) begin
        exp_q.push_back({we, addr, (we ? wdata : 8'h00), ref_regs[addr]});
        if (we) ref_regs[addr] = wdata;
        accepted++;
      end
      @(posedge clk);
      #1;
      if (!hold_valid) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (responses < target && n < 5000) begin @(negedge clk); n++; end
    if (responses < target) fail_now("rsp_timeout");
  endtask

  // Register-file slave on the SPI pins: byte 1 returns the addressed register.
  initial begin : slave
    int s_bits; logic [15:0] s_shift; logic [7:0] s_out; logic s_sck;
    s_bits = 0; s_shift = 16'h0; s_out = 8'h0; s_sck = 1'b0; bus.MISO = 1'b0;
    forever begin
      @(bus.CS or bus.SCK);
      if (bus.CS) begin
        if (s_bits == 16 && s_shift[15]) slave_regs[s_shift[14:8]] = s_shift[7:0];
        s_bits = 0; bus.MISO = 1'b0;
      end else if (bus.SCK && !s_sck) begin
        s_shift = {s_shift[14:0], bus.MOSI};
        s_bits++;
        if (s_bits == 8) s_out = slave_regs[s_shift[6:0]];
        if (s_bits == 16) frame_q.push_back(s_shift);
      end else if (!bus.SCK && s_sck && s_bits >= 8 && s_bits < 16) begin
        bus.MISO = s_out[15 - s_bits];
      end
      s_sck = bus.SCK;
    end
  end

  initial begin : cs_watch
    logic p;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (p && !bus.CS) cs_fall_cyc = cyc;
      if (!p && bus.CS) cs_rise_cyc = cyc;
      p = bus.CS;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        responses++;
        if (exp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          if (frame_q.size() == 0) fail_now("mosi_frame_missing");
          else check("mosi_frame", frame_q.pop_front(), e.frame);
        end
      end
    end
  end

  // Divider sweep: one write per instance, timing measured from the accept edge.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SD = (g == 0) ? 4 : ((g == 1) ? 7 : 255);
    spi_reg_master_if sif();
    spi_reg_master #(.CLK_DIV(SD)) u_sw (.clk(clk), .rst(rst_sw), .bus(sif));

    initial begin : sw
      int n, cs_first, cs_last, rsp_k, rsp_cnt, rdy_k, rises, runs, run, run_min, run_max;
      logic p_sck, p_cs;
      logic [15:0] mframe;
      logic [6:0] a;
      logic [7:0] w;
      sif.req_valid = 1'b0; sif.req_we = 1'b0; sif.req_addr = 7'h0; sif.req_wdata = 8'h0;
      sif.MISO = 1'b0;
      a = 7'($urandom); w = 8'($urandom);
      n = 0;
      @(negedge clk);
      while ((rst_sw || !sif.req_ready) && n < 100) begin @(negedge clk); n++; end
      sif.req_we = 1'b1; sif.req_addr = a; sif.req_wdata = w; sif.req_valid = 1'b1;
      @(posedge clk);
      #1 sif.req_valid = 1'b0;
      cs_first = -1; cs_last = -1; rsp_k = -1; rsp_cnt = 0; rdy_k = -1; rises = 0;
      runs = 0; run = 0; run_min = 100000; run_max = 0;
      p_sck = 1'b0; p_cs = 1'b1; mframe = 16'h0;
      for (int k = 1; k <= 36 * SD + 2; k++) begin
        @(negedge clk);
        if (!sif.CS) begin
          if (cs_first < 0) cs_first = k;
          cs_last = k;
        end
        if (sif.rsp_valid) begin
          rsp_cnt++;
          if (rsp_k < 0) rsp_k = k;
        end
        if (sif.req_ready && rdy_k < 0) rdy_k = k;
        if (sif.SCK && !p_sck) begin
          rises++;
          mframe = {mframe[14:0], sif.MOSI};
        end
        if (!p_cs && (sif.CS || sif.SCK != p_sck)) begin
          runs++;
          if (run < run_min) run_min = run;
          if (run > run_max) run_max = run;
          run = 0;
        end
        if (!sif.CS) run++;
        p_sck = sif.SCK; p_cs = sif.CS;
      end
      check($sformatf("sw%0d_cs_first", SD), cs_first, 1);
      check($sformatf("sw%0d_cs_last", SD), cs_last, 33 * SD);
      check($sformatf("sw%0d_rsp_cycle", SD), rsp_k, 1 + 33 * SD);
      check($sformatf("sw%0d_rsp_count", SD), rsp_cnt, 1);
      check($sformatf("sw%0d_ready_cycle", SD), rdy_k, 1 + 35 * SD);
      check($sformatf("sw%0d_sck_rises", SD), rises, 16);
      check($sformatf("sw%0d_phase_runs", SD), runs, 33);
      check($sformatf("sw%0d_phase_min", SD), run_min, SD);
      check($sformatf("sw%0d_phase_max", SD), run_max, SD);
      check($sformatf("sw%0d_mosi_frame", SD), mframe, {1'b1, a, w});
      sweep_done++;
    end
  end

  initial begin : main
    logic [7:0] v;
    int n, r, resp_before;
    logic p;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 7'h0; bus.req_wdata = 8'h0;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      ref_regs[i] = v;
      slave_regs[i] = v;
    end
    ref_regs[42] = 8'h3C;
    slave_regs[42] = 8'h3C;

    // Reset asserted between edges: outputs must settle with no clock.
    #1 rst = 1'b1; rst_sw = 1'b1;
    #2;
    check("rst_cs", bus.CS, 1);
    check("rst_sck", bus.SCK, 0);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; rst_sw = 1'b0;

    issue(1'b1, 7'h05, 8'hA5, 1'b1, 1'b0);
    wait_rsp(accepted);
    check("slave_regwr_5", slave_regs[5], 8'hA5);

    issue(1'b0, 7'h2A, 8'($urandom), 1'b1, 1'b0);
    wait_rsp(accepted);
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.rsp_rdata, 8'h3C);

    // Back-to-back with req_valid held high throughout.
    issue(1'b1, 7'($urandom), 8'($urandom), 1'b1, 1'b1);
    issue(1'b0, 7'($urandom), 8'($urandom), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_cs_gap", cs_fall_cyc - cs_rise_cyc, 2 * D + 1);
    wait_rsp(accepted);

    // Mid-frame request pulse must be dropped.
    issue(1'b1, 7'($urandom), 8'($urandom), 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 7'($urandom); bus.req_wdata = 8'($urandom);
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b0;
    wait_rsp(accepted);
    repeat (60) @(negedge clk);
    check("ignored_req_cs_idle", bus.CS, 1);
    check("ignored_req_count", responses, accepted);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom), 7'($urandom), 8'($urandom), 1'b1, 1'b0);
    end
    wait_rsp(accepted);

    // Abort a frame during bit 8 with SCK and MOSI both high.
    resp_before = responses;
    issue(1'b1, 7'h7F, 8'hFF, 1'b0, 1'b0);
    r = 0; n = 0; p = bus.SCK;
    while (r < 8 && n < 2000) begin
      @(negedge clk);
      if (bus.SCK && !p) r++;
      p = bus.SCK;
      n++;
    end
    if (r < 8) fail_now("abort_sck_timeout");
    check("pre_abort_mosi", bus.MOSI, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_cs", bus.CS, 1);
    check("abort_sck", bus.SCK, 0);
    check("abort_mosi", bus.MOSI, 0);
    check("abort_ready", bus.req_ready, 1);
    check("abort_rdata", bus.rsp_rdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_rsp", responses, resp_before);

    issue(1'b1, 7'h00, 8'h5A, 1'b1, 1'b0);
    wait_rsp(accepted);
    check("slave_regwr_0", slave_regs[0], 8'h5A);

    n = 0;
    while (sweep_done < 3 && n < 20000) begin @(negedge clk); n++; end
    if (sweep_done < 3) fail_now("sweep_timeout");
    repeat (5) @(negedge clk);
    check("total_rsp_count", responses, accepted);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
